// File: rtl/bank_rdata_collector_pkg.sv
// Shared banking constants and types for the bank read-data collector.
package bank_rdata_collector_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int PENDING_W  = 3;

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;

    typedef struct packed {
        logic      valid;
        bank_sel_t tag;
    } tag_entry_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic en, input bank_sel_t sel);
        logic [NUM_BANKS-1:0] oh;
        oh = '0;
        if (en) oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bank_rdata_collector_if.sv
// Request/return bus between a reader and the bank read-data collector.
interface bank_rdata_collector_if
    import bank_rdata_collector_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) ();

    logic                  i_rd_en;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [NUM_BANKS-1:0]  o_bank_rd_en;
    logic [DATA_WIDTH-1:0] i_bank_rdata0;
    logic [DATA_WIDTH-1:0] i_bank_rdata1;
    logic [DATA_WIDTH-1:0] i_bank_rdata2;
    logic [DATA_WIDTH-1:0] i_bank_rdata3;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic [PENDING_W-1:0]  o_pending;

    modport master (
        output i_rd_en, i_address,
        output i_bank_rdata0, i_bank_rdata1, i_bank_rdata2, i_bank_rdata3,
        input  o_bank_rd_en, o_rdata, o_rvalid, o_pending
    );

    modport slave (
        input  i_rd_en, i_address,
        input  i_bank_rdata0, i_bank_rdata1, i_bank_rdata2, i_bank_rdata3,
        output o_bank_rd_en, o_rdata, o_rvalid, o_pending
    );

endinterface

// File: rtl/bank_tag_pipe.sv
// Fixed-depth shift register carrying {valid, bank tag} alongside in-flight bank reads.
module bank_tag_pipe
    import bank_rdata_collector_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      valid_i,
    input  bank_sel_t tag_i,
    output logic      valid_o,
    output bank_sel_t tag_o
);

    tag_entry_t [DEPTH-1:0] stage_q;
    tag_entry_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = '{valid: valid_i, tag: tag_i};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q[DEPTH-1].valid;
    assign tag_o   = stage_q[DEPTH-1].tag;

endmodule

// File: rtl/bank_rdata_collector.sv
// Fans a read out to one of four banks and returns the selected bank's data
// in issue order after a fixed RD_LATENCY+1 cycles.
module bank_rdata_collector
    import bank_rdata_collector_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input logic                   i_clk,
    input logic                   i_rst,
    bank_rdata_collector_if.slave bus
);

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("bank_rdata_collector: RD_LATENCY out of range");
    end

    bank_sel_t             rd_sel;
    bank_sel_t             ret_tag;
    logic                  ret_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [PENDING_W-1:0]  pending_q, pending_d;
    logic                  unused_addr_lo;

    assign rd_sel           = bus.i_address[ADDR_WIDTH-1 -: BANK_SEL_W];
    assign unused_addr_lo   = ^bus.i_address[ADDR_WIDTH-BANK_SEL_W-1:0];
    assign bus.o_bank_rd_en = bank_onehot(bus.i_rd_en, rd_sel);

    bank_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .valid_i (bus.i_rd_en),
        .tag_i   (rd_sel),
        .valid_o (ret_valid),
        .tag_o   (ret_tag)
    );

    always_comb begin
        sel_data = bus.i_bank_rdata0;
        case (ret_tag)
            2'd1:    sel_data = bus.i_bank_rdata1;
            2'd2:    sel_data = bus.i_bank_rdata2;
            2'd3:    sel_data = bus.i_bank_rdata3;
            default: sel_data = bus.i_bank_rdata0;
        endcase
        rdata_d  = ret_valid ? sel_data : rdata_q;
        rvalid_d = ret_valid;
        // A read counts as outstanding until the cycle its o_rvalid is shown.
        pending_d = pending_q + PENDING_W'(bus.i_rd_en) - PENDING_W'(rvalid_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            pending_q <= pending_d;
        end
    end

    assign bus.o_rdata   = rdata_q;
    assign bus.o_rvalid  = rvalid_q;
    assign bus.o_pending = pending_q;

endmodule

// File: tb/tb_bank_rdata_collector.sv
// Scoreboard bench: three collectors (RD_LATENCY 1..3) share one stimulus stream.
module tb_bank_rdata_collector;
    import bank_rdata_collector_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int NL = 3;
    localparam int N  = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rd_en;
    logic [AW-1:0] address;
    logic [DW-1:0] bank_d [4];

    bit            rd_tab  [N];
    bit            rst_tab [N];
    logic [AW-1:0] addr_tab[N];
    logic [DW-1:0] bdata   [N+8][4];

    typedef struct {
        int            lane;
        int            issue;
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    int cyc         = -1;
    int vectors     = 0;
    int miscompares = 0;
    bit done        = 1'b0;

    logic          rvalid_w[NL];
    logic [DW-1:0] rdata_w [NL];
    logic [2:0]    pend_w  [NL];
    logic [3:0]    bre_w   [NL];
    logic [DW-1:0] last_exp[NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        bank_rdata_collector_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        assign bus.i_rd_en       = rd_en;
        assign bus.i_address     = address;
        assign bus.i_bank_rdata0 = bank_d[0];
        assign bus.i_bank_rdata1 = bank_d[1];
        assign bus.i_bank_rdata2 = bank_d[2];
        assign bus.i_bank_rdata3 = bank_d[3];

        bank_rdata_collector #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .RD_LATENCY (g + 1)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus.slave)
        );

        assign rvalid_w[g] = bus.o_rvalid;
        assign rdata_w[g]  = bus.o_rdata;
        assign pend_w[g]   = bus.o_pending;
        assign bre_w[g]    = bus.o_bank_rd_en;
    end

    task automatic check(input string name, input int lane, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d cyc%0d: got %0h expected %0h", name, lane, cyc, act, exp);
        end
    endtask

    // Monitor: compares each lane's outputs against the queued expectations.
    always @(negedge clk) begin
        if (cyc >= 1 && !done) begin
            for (int k = 0; k < NL; k++) begin
                int         idx;
                int         pend;
                logic [3:0] exp_bre;
                idx  = -1;
                pend = 0;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (sb_q[i].lane == k) begin
                        if (idx < 0) idx = i;
                        if (sb_q[i].issue < cyc) pend++;
                    end
                end
                exp_bre = 4'b0001 << address[AW-1 -: 2];
                if (!rd_en) exp_bre = 4'b0000;
                check("bank_rd_en", k, 32'(bre_w[k]), 32'(exp_bre));
                if (!rst) check("pending", k, 32'(pend_w[k]), 32'(pend));
                if (idx >= 0 && sb_q[idx].due == cyc) begin
                    check("rvalid", k, 32'(rvalid_w[k]), 32'd1);
                    check("rdata", k, 32'(rdata_w[k]), 32'(sb_q[idx].data));
                    last_exp[k] = sb_q[idx].data;
                    sb_q.delete(idx);
                end else begin
                    check("rvalid", k, 32'(rvalid_w[k]), 32'd0);
                    check("rdata_hold", k, 32'(rdata_w[k]), 32'(last_exp[k]));
                end
                if (rst) last_exp[k] = '0;
            end
        end
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            rd_tab[c]   = 1'b0;
            rst_tab[c]  = 1'b0;
            addr_tab[c] = AW'($urandom);
        end
        for (int c = 0; c < N + 8; c++) begin
            for (int b = 0; b < 4; b++) bdata[c][b] = DW'($urandom);
        end

        // Initial reset with an untracked read issued during it.
        rst_tab[0] = 1'b1;
        rst_tab[1] = 1'b1;
        rd_tab[1]  = 1'b1;
        addr_tab[1] = 6'h25;
        // Single read to bank 2.
        rd_tab[3] = 1'b1;
        addr_tab[3] = 6'h25;
        for (int c = 4; c <= 6; c++) bdata[c][2] = 8'hA5;
        // Back-to-back across all banks.
        for (int i = 0; i < 4; i++) begin
            rd_tab[8+i]   = 1'b1;
            addr_tab[8+i] = AW'(i * 16);
        end
        for (int c = 8; c <= 15; c++) begin
            bdata[c][0] = 8'h11;
            bdata[c][1] = 8'h22;
            bdata[c][2] = 8'h33;
            bdata[c][3] = 8'h44;
        end
        // Isolated bank-1 read for latency/pending profile.
        rd_tab[16] = 1'b1;
        addr_tab[16] = 6'h17;
        // Reset mid-flight.
        rd_tab[22] = 1'b1;
        rd_tab[23] = 1'b1;
        rst_tab[24] = 1'b1;
        // Return of 5C followed by a long idle stretch.
        rd_tab[28] = 1'b1;
        addr_tab[28] = 6'h3A;
        for (int c = 29; c <= 31; c++) bdata[c][3] = 8'h5C;
        // Random traffic, then an idle tail to drain.
        for (int c = 46; c < N - 8; c++) begin
            rd_tab[c]  = ($urandom_range(0, 9) < 7);
            rst_tab[c] = ($urandom_range(0, 99) < 3);
        end

        for (int k = 0; k < NL; k++) last_exp[k] = '0;
        rst     = 1'b1;
        rd_en   = 1'b0;
        address = '0;
        for (int b = 0; b < 4; b++) bank_d[b] = '0;

        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            cyc     = c;
            rd_en   = rd_tab[c];
            address = addr_tab[c];
            rst     = rst_tab[c];
            for (int b = 0; b < 4; b++) bank_d[b] = bdata[c][b];
            if (rst) begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].due > c) sb_q.delete(i);
                end
            end else if (rd_en) begin
                for (int k = 0; k < NL; k++) begin
                    exp_t e;
                    e.lane  = k;
                    e.issue = c;
                    e.due   = c + k + 2;
                    e.data  = bdata[c+k+1][int'(address[AW-1 -: 2])];
                    sb_q.push_back(e);
                end
            end
        end

        @(posedge clk);
        #1;
        cyc   = N;
        rd_en = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b1;
        check("drain", 0, 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bank_rdata_collector.md
BANK_RDATA_COLLECTOR -- requirements
Module: bank_rdata_collector

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: top-level address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the bank.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bank and top read-data width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal range 1..4: cycles from bank read enable to valid bank read data.
REQ-004 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_rd_en, input, 1: top-level read request, one read per asserted cycle.
REQ-007 SHALL have port i_address, input, ADDR_WIDTH: top-level read address.
REQ-008 SHALL have port o_bank_rd_en, output, 4: one-hot per-bank read enable.
REQ-009 SHALL have ports i_bank_rdata0..i_bank_rdata3, input, DATA_WIDTH each: bank read data.
REQ-010 SHALL have port o_rdata, output, DATA_WIDTH: returned read data.
REQ-011 SHALL have port o_rvalid, output, 1: o_rdata valid this cycle.
REQ-012 SHALL have port o_pending, output, 3: count of issued, not yet returned reads.

Function
REQ-013 SHALL drive o_bank_rd_en combinationally: bit k = i_rd_en AND (i_address top two bits == k); all zero when i_rd_en low.
REQ-014 SHALL push {valid=i_rd_en, tag=i_address top two bits} into a RD_LATENCY-deep tag shift register every cycle.
REQ-015 SHALL, when the tag register's output stage is valid, register the i_bank_rdataN selected by its tag into o_rdata and assert o_rvalid the next cycle.
REQ-016 SHALL give fixed latency: o_rvalid exactly RD_LATENCY+1 cycles after the i_rd_en cycle.
REQ-017 SHALL accept back-to-back reads every cycle, any bank order, with no stall; returns SHALL be in issue order.
REQ-018 SHALL hold o_rdata at its last value and deassert o_rvalid in cycles with no return.
REQ-019 SHALL ignore the unselected banks' read data entirely.
REQ-020 SHALL update o_pending = o_pending + issue - return each cycle; simultaneous issue and return leave it unchanged; maximum value RD_LATENCY+1 and it never wraps.
REQ-021 SHALL treat i_address lower bits as don't-care; they are not routed by this block.

Reset
REQ-022 SHALL, while i_rst is high, clear all tag valid bits, o_rvalid=0, o_rdata=0, o_pending=0.
REQ-023 SHALL drop reads in flight at reset: no o_rvalid ever results from an i_rd_en issued before or during a reset cycle.
REQ-024 SHALL still drive o_bank_rd_en per REQ-013 during reset (combinational), but SHALL not track those reads.

Structure
REQ-025 SHALL place the bank count (4), bank-select width (2), and the RD_LATENCY legal range in the shared banking package.
REQ-026 SHALL implement the tag pipeline as one sub-module, bank_tag_pipe (parameterised depth, valid plus 2-bit tag).
REQ-027 SHALL contain no latches; every combinational output SHALL be assigned on all paths.

Verification
REQ-028 SHALL test single read: RD_LATENCY=1, i_address=6'h25, bank2 data 8'hA5 -> o_bank_rd_en=4'b0100, o_rvalid=1 with o_rdata=8'hA5 two cycles later.
REQ-029 SHALL test back-to-back: addresses 6'h00,6'h10,6'h20,6'h30 on consecutive cycles, banks return 11,22,33,44 -> o_rdata 11,22,33,44 on four consecutive o_rvalid cycles.
REQ-030 SHALL test latency: RD_LATENCY=3, one read to bank 1 -> o_rvalid exactly 4 cycles after i_rd_en; o_pending goes 1,1,1,1,0.
REQ-031 SHALL test reset mid-flight: RD_LATENCY=2, issue reads at cycles 0 and 1, i_rst high at cycle 2 -> no o_rvalid; o_pending=0 and o_rdata=0 after reset.
REQ-032 SHALL test an idle hold: after a return of 8'h5C, 10 idle cycles -> o_rvalid=0, o_rdata stays 8'h5C, o_pending=0.
